// File: rtl/im_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory boot loader.
package im_pkg;
  localparam int IM_NMEM = 128;
  localparam int IM_AW   = 7;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} ld_state_t;

  typedef logic [31:0] inst_t;
endpackage

// File: rtl/im_loader_wr_stage.sv
// Registered beat-to-write stage: turns an accepted stream beat into a one-cycle
// memory write. Optional running checksum under IM_LOADER_CHECKSUM_EN.
module im_wr_stage #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic [AW-1:0] acc_idx,
  input  logic [DW-1:0] acc_data,
`ifdef IM_LOADER_CHECKSUM_EN
  input  logic          csum_clr,
  output logic [DW-1:0] csum,
`endif
  output logic          wr_en,
  output logic [AW-1:0] wr_add,
  output logic [DW-1:0] wr_data
);
  logic          wr_en_reg;
  logic [AW-1:0] wr_add_reg;
  logic [DW-1:0] wr_data_reg;

  // Address and data hold their last values between beats; only the strobe pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_reg   <= 1'b0;
      wr_add_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= acc;
      if (acc) begin
        wr_add_reg  <= acc_idx;
        wr_data_reg <= acc_data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_add  = wr_add_reg;
  assign wr_data = wr_data_reg;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_reg;

  // Accumulates on the write cycle, so the final word is included by ld_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_reg <= '0;
    end else if (csum_clr) begin
      csum_reg <= '0;
    end else if (wr_en_reg) begin
      csum_reg <= csum_reg + wr_data_reg;
    end
  end

  assign csum = csum_reg;
`endif
endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: streams ld_len words into slots 0..ld_len-1
// and holds fetch stalled until done. Define IM_LOADER_CHECKSUM_EN to add ld_csum.
module im_loader
  import im_pkg::*;
#(
  parameter int NMEM = IM_NMEM,
  parameter int AW   = IM_AW,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [31:0]   im_add,
  output logic [DW-1:0] im_data,
  output logic          im_en,
  output logic          im_rd_wr,
  output logic          core_stall,
  output logic          core_run,
  output logic          ld_busy,
  output logic          ld_done,
`ifdef IM_LOADER_CHECKSUM_EN
  output logic [DW-1:0] ld_csum,
`endif
  output logic          ld_err
);
  localparam logic [AW:0] NMEM_L = (AW+1)'(NMEM);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  ld_state_t   state_reg, state_next;
  logic [AW:0] len_reg, len_next;
  logic [AW:0] cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        done_reg, done_next;
  logic        start_ok;
  logic        accept;
  logic        len_legal;
  logic [AW-1:0] wr_add;

  assign len_legal = (ld_len != '0) && (ld_len <= NMEM_L);
  assign accept    = s_valid && (state_reg == LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
    end
  end

  // cnt_reg counts accepted beats; the write stage replays it one cycle later as im_add.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    start_ok   = 1'b0;
    case (state_reg)
      IDLE, RUN: begin
        if (ld_start) begin
          if (len_legal) begin
            state_next = LOAD;
            len_next   = ld_len;
            cnt_next   = '0;
            err_next   = 1'b0;
            start_ok   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_next = cnt_reg + ONE;
          if (cnt_reg + ONE == len_reg) state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = RUN;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  im_wr_stage #(.AW(AW), .DW(DW)) u_wr (
    .clk      (clk),
    .rst      (rst),
    .acc      (accept),
    .acc_idx  (cnt_reg[AW-1:0]),
    .acc_data (s_data),
`ifdef IM_LOADER_CHECKSUM_EN
    .csum_clr (start_ok),
    .csum     (ld_csum),
`endif
    .wr_en    (im_rd_wr),
    .wr_add   (wr_add),
    .wr_data  (im_data)
  );

  assign im_add     = {{(32-AW){1'b0}}, wr_add};
  assign s_ready    = (state_reg == LOAD);
  assign ld_busy    = (state_reg == LOAD) || (state_reg == FLUSH);
  assign im_en      = ld_busy;
  assign core_run   = (state_reg == RUN);
  assign core_stall = !core_run;
  assign ld_done    = done_reg;
  assign ld_err     = err_reg;

`ifndef IM_LOADER_CHECKSUM_EN
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif
endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued by the stimulus and
// checked by a negedge monitor; status outputs are checked inline.
module tb_im_loader;
  import im_pkg::*;

  localparam int AW = IM_AW;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_start = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic          s_valid = 1'b0;
  inst_t         s_data = '0;
  logic          s_ready;
  logic [31:0]   im_add;
  logic [DW-1:0] im_data;
  logic          im_en, im_rd_wr, core_stall, core_run, ld_busy, ld_done, ld_err;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [DW-1:0] ld_csum;
`endif

  im_loader dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_len     (ld_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .im_add     (im_add),
    .im_data    (im_data),
    .im_en      (im_en),
    .im_rd_wr   (im_rd_wr),
    .core_stall (core_stall),
    .core_run   (core_run),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
`ifdef IM_LOADER_CHECKSUM_EN
    .ld_csum    (ld_csum),
`endif
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  inst_t       words [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ld_done) done_cnt++;
    if (im_rd_wr) begin
      $display("write add=%0d data=%h", im_add, im_data);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_add", im_add, mon_e[63:32]);
        chk("wr_data", im_data, mon_e[31:0]);
      end
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_im_en"}, im_en, 0);
    chk({tag, "_im_rd_wr"}, im_rd_wr, 0);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_ld_busy"}, ld_busy, 0);
    chk({tag, "_ld_done"}, ld_done, 0);
    chk({tag, "_ld_err"}, ld_err, 0);
    chk({tag, "_core_stall"}, core_stall, 1);
    chk({tag, "_im_add"}, im_add, 0);
    chk({tag, "_im_data"}, im_data, 0);
  endtask

  task automatic start(input int len);
    @(posedge clk); #1;
    ld_start = 1'b1;
    ld_len   = (AW+1)'(len);
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  // Full load: words[0..len-1], 'gap' idle cycles between beats; 'poke' fires an
  // illegal ld_start mid-load, which must be ignored.
  task automatic load(input int len, input int gap, input bit poke);
    int d0;
    d0 = done_cnt;
    start(len);
    @(negedge clk);
    chk("start_busy", ld_busy, 1);
    chk("start_stall", core_stall, 1);
    chk("start_err_clr", ld_err, 0);
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      chk("s_ready", s_ready, 1);
      exp_q.push_back({32'(i), words[i]});
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = 32'hDEADBEEF;
      if (i != len - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (poke && i == 0 && g == 0) begin
            ld_start = 1'b1;
            ld_len   = '0;
          end
          @(posedge clk); #1;
          ld_start = 1'b0;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    chk("flush_s_ready", s_ready, 0);
    chk("flush_busy", ld_busy, 1);
    chk("flush_stall", core_stall, 1);
    chk("flush_im_en", im_en, 1);
    chk("flush_done", ld_done, 0);
    chk("flush_err", ld_err, 0);
    @(negedge clk);
    chk("run_done", ld_done, 1);
    chk("run_stall", core_stall, 0);
    chk("run_core_run", core_run, 1);
    chk("run_busy", ld_busy, 0);
    chk("run_im_en", im_en, 0);
    @(negedge clk);
    chk("done_pulse_end", ld_done, 0);
    chk("done_once", 32'(done_cnt - d0), 1);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) words[i] = 32'h20010001 + 32'(i);
    load(4, 0, 1'b0);

    // Illegal start while running: error flag set, core keeps running.
    start(0);
    @(negedge clk);
    chk("run_illegal_err", ld_err, 1);
    chk("run_illegal_core_run", core_run, 1);
    chk("run_illegal_stall", core_stall, 0);

    words[0] = 32'hA0000001; words[1] = 32'hA0000002; words[2] = 32'hA0000003;
    load(3, 1, 1'b1);

    // Back to IDLE, then illegal lengths.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start(0);
    @(negedge clk);
    chk("len0_err", ld_err, 1);
    chk("len0_stall", core_stall, 1);
    chk("len0_busy", ld_busy, 0);
    chk("len0_s_ready", s_ready, 0);
    start(129);
    @(negedge clk);
    chk("len129_err", ld_err, 1);
    chk("len129_stall", core_stall, 1);
    chk("len129_busy", ld_busy, 0);
    words[0] = 32'h5555AAAA;
    load(1, 0, 1'b0);

    for (int i = 0; i < 128; i++) words[i] = 32'h30000000 + 32'(i);
    load(128, 0, 1'b0);

    // Reset after two of five beats.
    for (int i = 0; i < 5; i++) words[i] = 32'h40000000 + 32'(i);
    start(5);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      exp_q.push_back({32'(i), words[i]});
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 reset_vals("midload_rst");
    chk("midload_queue", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    words[0] = 32'h60000000; words[1] = 32'h60000001;
    load(2, 0, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
    words[0] = 32'hFFFFFFFF; words[1] = 32'h00000002;
    load(2, 0, 1'b0);
    chk("csum", ld_csum, 32'h00000001);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time sequencer for the instruction memory.
- Accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive instruction-memory word slots, starting at slot 0, through the memory's write port (im_add/im_data/im_en/im_rd_wr).
- Holds the pipeline stalled until the whole program is written, then releases fetch.
- Sits between the test driver/host and the instruction memory plus fetch-stall logic.

Parameters:
- NMEM, 128: instruction memory depth in words; legal ld_len range is 1..NMEM.
- AW, 7: word-address width, equal to clog2(NMEM).
- DW, 32: instruction word width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ld_start  in  1  one-cycle request to begin a program load.
- ld_len  in  AW+1  number of words to load; sampled only when ld_start is accepted.
- s_valid  in  1  stream word valid.
- s_data  in  DW  stream instruction word.
- s_ready  out  1  loader can accept a stream word.
- im_add  out  32  write word index (counter value, zero-extended to 32 bits).
- im_data  out  DW  write data.
- im_en  out  1  memory enable; high during LOAD and FLUSH.
- im_rd_wr  out  1  one-cycle write strobe per accepted word.
- core_stall  out  1  fetch stall; high in every state except RUN.
- core_run  out  1  high in RUN.
- ld_busy  out  1  high in LOAD and FLUSH.
- ld_done  out  1  one-cycle pulse on entry to RUN.
- ld_err  out  1  sticky flag for an illegal ld_len; cleared by reset or by a legal ld_start.

Behaviour:
- Reset values (rst low, asynchronous):
  - State IDLE, counter 0.
  - s_ready, im_en, im_rd_wr, core_run, ld_busy, ld_done, ld_err all 0.
  - core_stall 1; im_add and im_data 0.
- States:
  - IDLE -> LOAD on ld_start when 1 <= ld_len <= NMEM. This captures ld_len, clears the counter and clears ld_err.
  - IDLE on ld_start with ld_len == 0 or ld_len > NMEM: set ld_err = 1 and stay in IDLE.
  - LOAD: s_ready = 1. A beat is accepted when s_valid && s_ready.
    - On the next cycle: im_rd_wr = 1, im_add = counter, im_data = the registered s_data; the counter then increments.
    - s_valid low: no write, im_rd_wr = 0. Stream gaps are allowed.
    - When the accepted beat is number len (the final word), go to FLUSH; s_ready drops in the same cycle the final beat is accepted.
  - FLUSH: lasts exactly 1 cycle. The final write strobe occurs in this cycle. Go to RUN.
  - RUN: core_stall = 0, core_run = 1; ld_done is high for the first RUN cycle only.
    - ld_start with a legal ld_len -> LOAD; core_stall rises on the next cycle.
    - ld_start with an illegal ld_len -> ld_err = 1; stay in RUN.
- Latency:
  - A beat accepted at cycle N is written at cycle N+1.
  - Final beat accepted at cycle N -> FLUSH at N+1 -> RUN, with stall released and ld_done, at N+2.
- ld_start during LOAD or FLUSH is ignored: no state change and no ld_err.
- Counter:
  - AW+1 bits wide, so len == NMEM is detected without wrap.
  - im_add never exceeds NMEM-1.
- Reset mid-load: immediate return to reset values. Memory contents are left to the memory's own reset. No partial release of core_stall.
- Exactly one im_rd_wr pulse per accepted beat; never two writes to the same slot in one load.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output ld_csum (DW bits): the mod-2^DW sum of all accepted words.
  - Cleared to 0 on legal ld_start acceptance.
  - Updated with each write.
  - Stable and valid from the ld_done cycle until the next legal ld_start.
  - Reset value 0.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package im_pkg:
  - Typedef enum ld_state_t {IDLE, LOAD, FLUSH, RUN}, 2 bits.
  - Constants IM_NMEM = 128 and IM_AW = 7.
  - Typedef inst_t (logic [31:0]).
- One sub-module, im_wr_stage: the registered beat-to-write stage (im_rd_wr/im_add/im_data plus optional checksum). The FSM and counter stay in im_loader.

Test Plan:
- Reset, then ld_start with ld_len = 4 and words 0x20010001..0x20010004 streamed back-to-back -> four im_rd_wr pulses at im_add 0..3, FLUSH, ld_done and core_stall = 0 two cycles after the 4th accept.
- ld_len = 3 with s_valid gaps (1 idle cycle between beats) -> writes only on accepted beats; im_add 0, 1, 2 with no duplicates.
- ld_start with ld_len = 0, and separately with ld_len = 129 -> ld_err = 1, state IDLE, core_stall = 1, no im_rd_wr; then ld_len = 1 -> ld_err cleared, load completes.
- ld_len = 128 (full memory) -> last write at im_add = 127 and no wrap to 0; ld_done once.
- rst asserted after 2 of 5 beats -> all outputs at reset values immediately; a new ld_start with ld_len = 2 restarts at im_add = 0.
- With IM_LOADER_CHECKSUM_EN and words 0xFFFFFFFF, 0x00000002 -> ld_csum = 0x00000001 at ld_done.
